// File: rtl/regfile_access_ctrl.sv
// Write-port arbiter and debug access controller for the 16x32 register file.
// Optional post-reset zeroing sweep is built when RF_INIT_SWEEP_EN is defined.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 16,
    parameter int INDEX_WIDTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_write_en_WB,
    input  logic [INDEX_WIDTH-1:0] i_rd_WB,
    input  logic [DATA_WIDTH-1:0]  i_data_WB,
    input  logic                   i_dbg_req,
    input  logic                   i_dbg_we,
    input  logic [INDEX_WIDTH-1:0] i_dbg_addr,
    input  logic [DATA_WIDTH-1:0]  i_dbg_wdata,
    output logic                   o_dbg_gnt,
    output logic                   o_dbg_rvalid,
    output logic [DATA_WIDTH-1:0]  o_dbg_rdata,
    output logic                   o_rf_we,
    output logic [INDEX_WIDTH-1:0] o_rf_waddr,
    output logic [DATA_WIDTH-1:0]  o_rf_wdata,
    output logic [INDEX_WIDTH-1:0] o_rf_raddr,
    input  logic [DATA_WIDTH-1:0]  i_rf_rdata,
    output logic                   o_stall_ID,
    output logic                   o_init_busy
);

    typedef enum logic {INIT, RUN} state_t;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REGS - 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t                 state;
    logic [INDEX_WIDTH-1:0] sweep_cnt;
    logic [CW-1:0]          starve_cnt;
    logic                   in_init, dbg_wr, dbg_rd, wr_deferred;

`ifdef RF_INIT_SWEEP_EN
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else if (state == INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == LAST_IDX) state <= RUN;
        end
    end
`else
    // No sweep: the register file's own reset clears it, counter stays parked.
    assign state     = RUN;
    assign sweep_cnt = LAST_IDX;
`endif

    assign in_init     = (state == INIT);
    assign o_init_busy = in_init;
    assign o_rf_raddr  = i_dbg_addr;
    assign dbg_wr      = i_dbg_req & i_dbg_we;
    assign dbg_rd      = i_dbg_req & ~i_dbg_we;

    // Core writeback always owns the write port; reads use the separate read port.
    always_comb begin
        o_rf_we    = 1'b0;
        o_rf_waddr = i_rd_WB;
        o_rf_wdata = i_data_WB;
        o_dbg_gnt  = 1'b0;
        if (in_init) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = sweep_cnt;
            o_rf_wdata = '0;
        end else if (i_write_en_WB) begin
            o_rf_we   = |i_rd_WB;
            o_dbg_gnt = dbg_rd;
        end else if (dbg_wr) begin
            o_dbg_gnt  = 1'b1;
            o_rf_we    = |i_dbg_addr;
            o_rf_waddr = i_dbg_addr;
            o_rf_wdata = i_dbg_wdata;
        end else begin
            o_dbg_gnt = dbg_rd;
        end
    end

    assign wr_deferred = ~in_init & dbg_wr & ~o_dbg_gnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            starve_cnt   <= '0;
            o_dbg_rvalid <= 1'b0;
            o_dbg_rdata  <= '0;
        end else begin
            if (!wr_deferred)             starve_cnt <= '0;
            else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;
            o_dbg_rvalid <= o_dbg_gnt & dbg_rd;
            if (o_dbg_gnt & dbg_rd) o_dbg_rdata <= i_rf_rdata;
        end
    end

    assign o_stall_ID = in_init | (starve_cnt >= LIMIT);

endmodule
